// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and decoded-result record for the arithmetic-unit sequencer
package alu_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} alu_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RESP = 2'b10} state_e;
  typedef struct packed {
    logic [15:0] result;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        zero;
    logic        neg;
    logic        ovf;
  } alu_rsp_t;
  function automatic logic [3:0] op_enables(alu_op_e op);
    return 4'b0001 << op;
  endfunction
endpackage

// File: rtl/alu_result_decoder.sv
// alu_result_decoder: turns the arithmetic unit's packed result into a normalised result plus flags
module alu_result_decoder
  import alu_pkg::*;
(
  input  logic [15:0] au_result,
  input  alu_op_e     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output alu_rsp_t    rsp
);
  // add/sub come back as 8-bit values and are re-sign-extended; div splits into quotient/remainder
  always_comb begin
    rsp = '0;
    rsp.result = (op == OP_ADD || op == OP_SUB) ? {{8{au_result[7]}}, au_result[7:0]} : au_result;
    rsp.quot = (op == OP_DIV) ? au_result[15:8] : 8'h00;
    rsp.rem = (op == OP_DIV) ? au_result[7:0] : 8'h00;
    rsp.zero = (op == OP_DIV) ? (au_result[15:8] == 8'h00) : (rsp.result == 16'h0000);
    rsp.neg = rsp.result[15];
    rsp.ovf = (op == OP_ADD) ? (a[7] == b[7] && au_result[7] != a[7]) :
              (op == OP_SUB) ? (a[7] != b[7] && au_result[7] != a[7]) :
              (op == OP_DIV) ? (a == 8'h80 && b == 8'hFF) : 1'b0;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op to the combinational arithmetic unit, waits the settle time, returns the decoded result (optional DIV_ZERO_CHECK_EN)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [1:0]  req_op,
  output logic [7:0]  au_a,
  output logic [7:0]  au_b,
  output logic [1:0]  au_op,
  output logic        au_add_en,
  output logic        au_sub_en,
  output logic        au_mul_en,
  output logic        au_div_en,
  input  logic [15:0] au_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_quot,
  output logic [7:0]  rsp_rem,
`ifdef DIV_ZERO_CHECK_EN
  output logic        rsp_dbz,
`endif
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_ovf
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  alu_op_e  op_q, op_d;
  logic [3:0] en_q, en_d;
  alu_rsp_t rsp_q, rsp_d, dec;
  logic     vld_q, vld_d;
  logic     dz;
`ifdef DIV_ZERO_CHECK_EN
  logic     dbz_q, dbz_d;
  assign dz = (req_op == OP_DIV) && (req_b == 8'h00);
  assign rsp_dbz = dbz_q;
`else
  assign dz = 1'b0;
`endif
  alu_result_decoder u_dec (
    .au_result(au_result),
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .rsp      (dec)
  );
  // next-state: accept in IDLE, count down in ISSUE, capture on count==0, release on rsp_ready
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    rsp_d = rsp_q;
    vld_d = vld_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d = dbz_q;
`endif
    if (state_q == IDLE && req_valid) begin
      a_d = req_a;
      b_d = req_b;
      op_d = alu_op_e'(req_op);
      cnt_d = CW'(SETTLE_CYCLES - 1);
      state_d = dz ? RESP : ISSUE;
      if (dz) begin
        rsp_d = '0;
        rsp_d.zero = 1'b1;
        vld_d = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d = 1'b1;
`endif
      end
    end else if (state_q == ISSUE) begin
      if (cnt_q == '0) begin
        state_d = RESP;
        rsp_d = dec;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      vld_d = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_d = 1'b0;
`endif
    end
    en_d = (state_d == ISSUE) ? op_enables(op_d) : 4'b0000;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_ADD;
      en_q <= '0;
      rsp_q <= '0;
      vld_q <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      en_q <= en_d;
      rsp_q <= rsp_d;
      vld_q <= vld_d;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q <= dbz_d;
`endif
    end
  end
  assign req_ready = (state_q == IDLE);
  assign au_a = a_q;
  assign au_b = b_q;
  assign au_op = op_q;
  assign {au_div_en, au_mul_en, au_sub_en, au_add_en} = en_q;
  assign rsp_valid = vld_q;
  assign rsp_result = rsp_q.result;
  assign rsp_quot = rsp_q.quot;
  assign rsp_rem = rsp_q.rem;
  assign rsp_zero = rsp_q.zero;
  assign rsp_neg = rsp_q.neg;
  assign rsp_ovf = rsp_q.ovf;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors against a behavioural arithmetic unit (honours DIV_ZERO_CHECK_EN)
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] req_a = '0, req_b = '0;
  logic [1:0] req_op = '0;
  logic [7:0] au_a, au_b;
  logic [1:0] au_op;
  logic au_add_en, au_sub_en, au_mul_en, au_div_en;
  logic [15:0] au_result;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [7:0] rsp_quot, rsp_rem;
  logic rsp_zero, rsp_neg, rsp_ovf;
`ifdef DIV_ZERO_CHECK_EN
  logic rsp_dbz;
`endif
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .au_a(au_a), .au_b(au_b), .au_op(au_op),
    .au_add_en(au_add_en), .au_sub_en(au_sub_en), .au_mul_en(au_mul_en), .au_div_en(au_div_en),
    .au_result(au_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
`ifdef DIV_ZERO_CHECK_EN
    .rsp_dbz(rsp_dbz),
`endif
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf)
  );
  // behavioural arithmetic unit: add is zero-extended 8-bit sum, div packs {quot,rem}, div-by-0 gives all ones
  function automatic logic [15:0] au_model(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    int sa, sb, q, r;
    logic [7:0] s;
    sa = $signed(a);
    sb = $signed(b);
    s = a + b;
    if (op == 2'd0) return {8'h00, s};
    if (op == 2'd1) return 16'(sa - sb);
    if (op == 2'd2) return 16'(sa * sb);
    if (sb == 0) return 16'hFFFF;
    q = sa / sb;
    r = sa % sb;
    return {q[7:0], r[7:0]};
  endfunction
  assign au_result = au_model(au_a, au_b, au_op);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // one full transaction; hold>0 keeps rsp_ready low that many cycles while offering a stray request
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [3:0] en, input logic [15:0] res, input logic [7:0] q, input logic [7:0] r,
                       input logic z, input logic n, input logic o, input int hold);
    for (int i = 0; i < 20 && !req_ready; i++) step();
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, ".en"}, 32'({au_div_en, au_mul_en, au_sub_en, au_add_en}), 32'(en));
    chk({tag, ".busy"}, 32'({req_ready, rsp_valid}), 32'b00);
    step();
    chk({tag, ".vld"}, 32'({rsp_valid, req_ready}), 32'b10);
    chk({tag, ".en_off"}, 32'({au_div_en, au_mul_en, au_sub_en, au_add_en}), 32'd0);
    chk({tag, ".res"}, 32'(rsp_result), 32'(res));
    chk({tag, ".qr"}, 32'({rsp_quot, rsp_rem}), 32'({q, r}));
    chk({tag, ".flags"}, 32'({rsp_zero, rsp_neg, rsp_ovf}), 32'({z, n, o}));
`ifdef DIV_ZERO_CHECK_EN
    chk({tag, ".dbz"}, 32'(rsp_dbz), 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      req_a = 8'h55;
      req_b = 8'h22;
      req_op = 2'd0;
      req_valid = 1'b1;
      step();
      chk({tag, ".hold_res"}, 32'({rsp_valid, rsp_result}), 32'({1'b1, res}));
      chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_au"}, 32'({au_a, au_b, au_op}), 32'({a, b, op}));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask
  initial begin
    step();
    step();
    chk("rst.rdy", 32'(req_ready), 32'd1);
    chk("rst.out", 32'({rsp_valid, au_add_en, au_sub_en, au_mul_en, au_div_en, rsp_zero, rsp_neg, rsp_ovf}), 32'd0);
    chk("rst.data", 32'({rsp_result, au_a, au_b}), 32'd0);
    rst = 1'b0;
    do_op("add_ovf", 8'd100, 8'd50, 2'd0, 4'b0001, 16'hFF96, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 0);
    do_op("sub", 8'd5, 8'd7, 2'd1, 4'b0010, 16'hFFFE, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    do_op("mul", 8'hF4, 8'd11, 2'd2, 4'b0100, 16'hFF7C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    do_op("div", 8'd17, 8'd5, 2'd3, 4'b1000, 16'h0302, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 0);
    do_op("div_ovf", 8'h80, 8'hFF, 2'd3, 4'b1000, 16'h8000, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 0);
    do_op("div_neg", 8'hF9, 8'd2, 2'd3, 4'b1000, 16'hFDFF, 8'hFD, 8'hFF, 1'b0, 1'b1, 1'b0, 0);
    do_op("add_zero", 8'hFF, 8'h01, 2'd0, 4'b0001, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    do_op("sub_ovf", 8'h80, 8'h01, 2'd1, 4'b0010, 16'h007F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    do_op("bp_mul", 8'd3, 8'd4, 2'd2, 4'b0100, 16'h000C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5);
`ifdef DIV_ZERO_CHECK_EN
    req_a = 8'd9;
    req_b = 8'd0;
    req_op = 2'd3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("dbz.en", 32'({au_div_en, au_mul_en, au_sub_en, au_add_en}), 32'd0);
    chk("dbz.vld", 32'({rsp_valid, rsp_dbz, req_ready}), 32'b110);
    chk("dbz.res", 32'({rsp_result, rsp_quot, rsp_rem}), 32'd0);
    chk("dbz.flags", 32'({rsp_zero, rsp_neg, rsp_ovf}), 32'b100);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("dbz.done", 32'({rsp_valid, rsp_dbz, req_ready}), 32'b001);
`else
    do_op("div0_pass", 8'd9, 8'd0, 2'd3, 4'b1000, 16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 0);
`endif
    req_a = 8'd1;
    req_b = 8'd2;
    req_op = 2'd1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mid_rst.en_before", 32'(au_sub_en), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst.en", 32'({au_div_en, au_mul_en, au_sub_en, au_add_en}), 32'd0);
    chk("mid_rst.state", 32'({rsp_valid, req_ready}), 32'b01);
    step();
    chk("mid_rst.quiet", 32'({rsp_valid, req_ready}), 32'b01);
    do_op("post_rst_add", 8'd0, 8'd0, 2'd0, 4'b0001, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
